// File: rtl/dff_pipe_pkg.sv
// Shared constants and helpers for the dff_pipe elastic delay line.
// Defaults are reused by the testbench so both sides agree on geometry.
package dff_pipe_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 3;
    localparam logic [DEF_WIDTH-1:0] DEF_RESET_VAL = 8'h00;

    // Width of an occupancy count able to hold 0..depth.
    function automatic int OCC_W(input int depth);
        return (depth < 1) ? 1 : $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/dff_pipe_stage.sv
// One valid+data stage of the pipe; loads whenever it is empty or its
// downstream neighbour can take its current contents.
module dff_pipe_stage
    import dff_pipe_pkg::*;
#(
    parameter int               WIDTH     = DEF_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             nr,
    output logic             rdy,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    logic             valid_r;
    logic [WIDTH-1:0] data_r;

    assign rdy   = ~valid_r | nr;
    assign valid = valid_r;
    assign data  = data_r;

    // Stage register: data only captured with a valid beat so X never lands in a live slot.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_r <= 1'b0;
            data_r  <= RESET_VAL;
        end else if (flush) begin
            valid_r <= 1'b0;
        end else if (rdy) begin
            valid_r <= in_valid;
            if (in_valid) begin
                data_r <= in_data;
            end
        end
    end

endmodule

// File: rtl/dff_pipe.sv
// Parametrised chain of DEPTH valid/ready register stages with bubble
// collapsing, synchronous flush and combinational occupancy.
module dff_pipe
    import dff_pipe_pkg::*;
#(
    parameter int               WIDTH     = DEF_WIDTH,
    parameter int               DEPTH     = DEF_DEPTH,
    parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(DEF_RESET_VAL)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [WIDTH-1:0]          in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic [OCC_W(DEPTH)-1:0]   occupancy
);

    localparam int OW = OCC_W(DEPTH);

    logic [DEPTH-1:0] v_s;
    logic [OW-1:0]    occ_s;
    logic             accept_s;

    assign accept_s = in_valid & in_ready;

    for (genvar k = 0; k < DEPTH; k++) begin : gen_stage
        logic             rdy_s;
        logic             nr_s;
        logic             prev_valid_s;
        logic [WIDTH-1:0] prev_data_s;
        logic [WIDTH-1:0] d_s;

        // Ready ripples back from the output; each stage is a separate net.
        if (k == DEPTH - 1) begin : gen_last
            assign nr_s = out_ready;
        end else begin : gen_mid
            assign nr_s = gen_stage[k+1].rdy_s;
        end

        if (k == 0) begin : gen_first
            assign prev_valid_s = accept_s;
            assign prev_data_s  = in_data;
        end else begin : gen_chain
            assign prev_valid_s = v_s[k-1];
            assign prev_data_s  = gen_stage[k-1].d_s;
        end

        dff_pipe_stage #(
            .WIDTH     (WIDTH),
            .RESET_VAL (RESET_VAL)
        ) u_stage (
            .clk      (clk),
            .reset    (reset),
            .flush    (flush),
            .in_valid (prev_valid_s),
            .in_data  (prev_data_s),
            .nr       (nr_s),
            .rdy      (rdy_s),
            .valid    (v_s[k]),
            .data     (d_s)
        );
    end

    assign in_ready  = gen_stage[0].rdy_s & ~flush;
    assign out_valid = v_s[DEPTH-1] & ~flush;
    assign out_data  = gen_stage[DEPTH-1].d_s;
    assign occupancy = occ_s;

    // Population count of the stage valid bits.
    always_comb begin
        occ_s = {OW{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            occ_s = occ_s + OW'(v_s[i]);
        end
    end

endmodule

// File: tb/tb_dff_pipe.sv
// Self-checking bench for dff_pipe: directed scenarios plus randomized traffic
// checked against an item-level model (ordered items with stage positions).
module tb_dff_pipe;
    import dff_pipe_pkg::*;

    localparam int D = DEF_DEPTH;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a = 1'b0;
    logic       flush = 1'b0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       a_in_ready, a_out_valid, b_in_ready, b_out_valid;
    logic [7:0] a_out_data, b_out_data;
    logic [1:0] a_occ, b_occ;

    logic rst_c = 1'b0;
    logic c_flush = 1'b0, c_in_valid = 1'b0, c_out_ready = 1'b0, c_in_data = 1'b0;
    logic c_in_ready, c_out_valid, c_out_data;
    logic [0:0] c_occ;

    int n_vec = 0;
    int n_miss = 0;

    dff_pipe #(.WIDTH(8), .DEPTH(3), .RESET_VAL(8'h00)) u_a (
        .clk(clk), .reset(rst_a), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_data(in_data), .out_valid(a_out_valid), .out_ready(out_ready),
        .out_data(a_out_data), .occupancy(a_occ));

    dff_pipe #(.WIDTH(8), .DEPTH(3), .RESET_VAL(8'hFF)) u_b (
        .clk(clk), .reset(rst_a), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_data(in_data), .out_valid(b_out_valid), .out_ready(out_ready),
        .out_data(b_out_data), .occupancy(b_occ));

    dff_pipe #(.WIDTH(1), .DEPTH(1), .RESET_VAL(1'b0)) u_c (
        .clk(clk), .reset(rst_c), .flush(c_flush), .in_valid(c_in_valid), .in_ready(c_in_ready),
        .in_data(c_in_data), .out_valid(c_out_valid), .out_ready(c_out_ready),
        .out_data(c_out_data), .occupancy(c_occ));

    // Reference model: items oldest first, each with its stage position.
    int         q_pos[$];
    logic [7:0] q_dat[$];
    bit         m_mv[D];

    // An item advances if the slot ahead is free or its occupant advances; the head leaves on out_ready.
    function automatic void calc_moves(bit ordy);
        for (int j = 0; j < q_pos.size(); j++) begin
            if (q_pos[j] == D - 1)              m_mv[j] = ordy;
            else if (j == 0)                    m_mv[j] = 1'b1;
            else if (q_pos[j-1] != q_pos[j] + 1) m_mv[j] = 1'b1;
            else                                m_mv[j] = m_mv[j-1];
        end
    endfunction

    function automatic bit model_in_ready(bit fl, bit ordy);
        int last;
        if (fl) return 1'b0;
        if (q_pos.size() == 0) return 1'b1;
        calc_moves(ordy);
        last = q_pos.size() - 1;
        if (q_pos[last] != 0) return 1'b1;
        return m_mv[last];
    endfunction

    function automatic bit model_out_valid(bit fl);
        return !fl && q_pos.size() > 0 && q_pos[0] == D - 1;
    endfunction

    task automatic model_edge();
        int         np[$];
        logic [7:0] nd[$];
        bit         acc;
        if (!rst_a || flush) begin
            q_pos.delete(); q_dat.delete();
            return;
        end
        acc = in_valid && model_in_ready(1'b0, out_ready);
        calc_moves(out_ready);
        for (int j = 0; j < q_pos.size(); j++) begin
            if (!m_mv[j]) begin
                np.push_back(q_pos[j]); nd.push_back(q_dat[j]);
            end else if (q_pos[j] != D - 1) begin
                np.push_back(q_pos[j] + 1); nd.push_back(q_dat[j]);
            end
        end
        if (acc) begin
            np.push_back(0); nd.push_back(in_data);
        end
        q_pos = np; q_dat = nd;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic drain();
        in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
        repeat (D + 1) tick();
    endtask

    task automatic test_reset();
        rst_a = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        n_vec++; if (a_out_valid !== 1'b0) begin n_miss++; $display("FAIL reset_out_valid: got %b want 0", a_out_valid); end
        n_vec++; if (a_out_data !== 8'h00) begin n_miss++; $display("FAIL reset_out_data: got %h want 00", a_out_data); end
        n_vec++; if (a_occ !== 2'd0) begin n_miss++; $display("FAIL reset_occ: got %0d want 0", a_occ); end
        n_vec++; if (a_in_ready !== 1'b1) begin n_miss++; $display("FAIL reset_in_ready: got %b want 1", a_in_ready); end
        n_vec++; if (b_out_data !== 8'hFF) begin n_miss++; $display("FAIL reset_b_out_data: got %h want ff", b_out_data); end
        q_pos.delete(); q_dat.delete();
        rst_a = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_stream();
        logic [7:0] got[$];
        int first_c = -1;
        int peak = 0;
        out_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            in_valid = (c < 3);
            in_data  = 8'hA1 + 8'(c);
            #1;
            n_vec++; if (a_out_valid !== model_out_valid(flush)) begin n_miss++; $display("FAIL stream_valid c%0d: got %b want %b", c, a_out_valid, model_out_valid(flush)); end
            if (a_out_valid) begin
                got.push_back(a_out_data);
                if (first_c < 0) first_c = c;
            end
            if (int'(a_occ) > peak) peak = int'(a_occ);
            tick();
        end
        n_vec++; if (first_c != 3) begin n_miss++; $display("FAIL stream_latency: got cycle %0d want 3", first_c); end
        n_vec++; if (got.size() != 3 || got[0] !== 8'hA1 || got[1] !== 8'hA2 || got[2] !== 8'hA3) begin
            n_miss++; $display("FAIL stream_order: got %p want A1 A2 A3", got); end
        n_vec++; if (peak != 3) begin n_miss++; $display("FAIL stream_peak_occ: got %0d want 3", peak); end
    endtask

    task automatic test_fill_stall();
        int idx = 0;
        out_ready = 1'b0; in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            in_data = 8'h10 + 8'(idx);
            #1;
            n_vec++; if (a_in_ready !== (c < 3)) begin n_miss++; $display("FAIL stall_in_ready c%0d: got %b want %b", c, a_in_ready, (c < 3)); end
            if (a_in_ready) idx++;
            tick();
        end
        #1;
        n_vec++; if (idx != 3) begin n_miss++; $display("FAIL stall_accepts: got %0d want 3", idx); end
        n_vec++; if (a_occ !== 2'd3) begin n_miss++; $display("FAIL stall_occ: got %0d want 3", a_occ); end
        out_ready = 1'b1; in_data = 8'h13;
        #1;
        n_vec++; if (a_in_ready !== 1'b1) begin n_miss++; $display("FAIL full_shift_in_ready: got %b want 1", a_in_ready); end
        n_vec++; if (a_out_valid !== 1'b1 || a_out_data !== 8'h10) begin n_miss++; $display("FAIL full_shift_out: got %b/%h want 1/10", a_out_valid, a_out_data); end
        tick();
        out_ready = 1'b0; in_valid = 1'b0;
        #1;
        n_vec++; if (a_occ !== 2'd3) begin n_miss++; $display("FAIL full_shift_occ: got %0d want 3", a_occ); end
        n_vec++; if (a_out_data !== 8'h11) begin n_miss++; $display("FAIL full_shift_next: got %h want 11", a_out_data); end
        drain();
    endtask

    task automatic test_bubble();
        out_ready = 1'b0;
        for (int c = 0; c < 7; c++) begin
            in_valid = (c == 0 || c == 3);
            in_data  = (c == 0) ? 8'h55 : 8'h66;
            tick();
        end
        in_valid = 1'b0;
        #1;
        n_vec++; if (a_occ !== 2'd2) begin n_miss++; $display("FAIL bubble_occ: got %0d want 2", a_occ); end
        n_vec++; if (q_pos.size() != 2 || q_pos[1] != D - 2) begin n_miss++; $display("FAIL bubble_model_pack: got %p want packed", q_pos); end
        out_ready = 1'b1;
        #1;
        n_vec++; if (a_out_valid !== 1'b1 || a_out_data !== 8'h55) begin n_miss++; $display("FAIL bubble_first: got %b/%h want 1/55", a_out_valid, a_out_data); end
        tick();
        #1;
        n_vec++; if (a_out_valid !== 1'b1 || a_out_data !== 8'h66) begin n_miss++; $display("FAIL bubble_second: got %b/%h want 1/66", a_out_valid, a_out_data); end
        tick();
        #1;
        n_vec++; if (a_out_valid !== 1'b0) begin n_miss++; $display("FAIL bubble_empty: got %b want 0", a_out_valid); end
    endtask

    task automatic test_flush();
        out_ready = 1'b0; in_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            in_data = 8'h30 + 8'(c);
            tick();
        end
        flush = 1'b1; in_data = 8'h77;
        #1;
        n_vec++; if (a_in_ready !== 1'b0) begin n_miss++; $display("FAIL flush_in_ready: got %b want 0", a_in_ready); end
        n_vec++; if (a_out_valid !== 1'b0) begin n_miss++; $display("FAIL flush_out_valid: got %b want 0", a_out_valid); end
        n_vec++; if (a_occ !== 2'd3) begin n_miss++; $display("FAIL flush_pre_occ: got %0d want 3", a_occ); end
        tick();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        #1;
        n_vec++; if (a_occ !== 2'd0) begin n_miss++; $display("FAIL flush_post_occ: got %0d want 0", a_occ); end
        for (int c = 0; c < 4; c++) begin
            n_vec++; if (a_out_valid !== 1'b0) begin n_miss++; $display("FAIL flush_leak c%0d: got %b want 0", c, a_out_valid); end
            tick();
            #1;
        end
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0; in_valid = 1'b1;
        repeat (2) begin
            in_data = 8'($urandom);
            tick();
        end
        in_valid = 1'b0;
        #1;
        n_vec++; if (a_occ !== 2'd2) begin n_miss++; $display("FAIL areset_pre_occ: got %0d want 2", a_occ); end
        #2 rst_a = 1'b0;
        #1;
        n_vec++; if (a_out_valid !== 1'b0 || a_out_data !== 8'h00 || a_occ !== 2'd0) begin
            n_miss++; $display("FAIL areset_a: got v%b d%h o%0d want v0 d00 o0", a_out_valid, a_out_data, a_occ); end
        n_vec++; if (a_in_ready !== 1'b1) begin n_miss++; $display("FAIL areset_in_ready: got %b want 1", a_in_ready); end
        n_vec++; if (b_out_valid !== 1'b0 || b_out_data !== 8'hFF || b_occ !== 2'd0) begin
            n_miss++; $display("FAIL areset_b: got v%b d%h o%0d want v0 dff o0", b_out_valid, b_out_data, b_occ); end
        q_pos.delete(); q_dat.delete();
        @(negedge clk);
        rst_a = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_random();
        bit exp_r, exp_v;
        for (int c = 0; c < 400; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 19) == 0);
            in_data   = in_valid ? 8'($urandom) : 8'hxx;
            #1;
            exp_r = model_in_ready(flush, out_ready);
            exp_v = model_out_valid(flush);
            n_vec++; if (a_in_ready !== exp_r) begin n_miss++; $display("FAIL rand_in_ready c%0d: got %b want %b", c, a_in_ready, exp_r); end
            n_vec++; if (a_out_valid !== exp_v) begin n_miss++; $display("FAIL rand_out_valid c%0d: got %b want %b", c, a_out_valid, exp_v); end
            if (exp_v) begin
                n_vec++; if (a_out_data !== q_dat[0]) begin n_miss++; $display("FAIL rand_out_data c%0d: got %h want %h", c, a_out_data, q_dat[0]); end
            end
            n_vec++; if (int'(a_occ) != q_pos.size()) begin n_miss++; $display("FAIL rand_occ c%0d: got %0d want %0d", c, a_occ, q_pos.size()); end
            tick();
        end
        flush = 1'b0;
        drain();
    endtask

    task automatic test_depth1();
        logic prev;
        rst_c = 1'b0;
        repeat (2) @(negedge clk);
        rst_c = 1'b1;
        c_in_valid = 1'b1; c_out_ready = 1'b1;
        prev = 1'($urandom);
        for (int c = 0; c < 16; c++) begin
            c_in_data = ~prev;
            #1;
            n_vec++; if (c_in_ready !== 1'b1) begin n_miss++; $display("FAIL d1_in_ready c%0d: got %b want 1", c, c_in_ready); end
            if (c > 0) begin
                n_vec++; if (c_out_valid !== 1'b1 || c_out_data !== prev) begin
                    n_miss++; $display("FAIL d1_delay c%0d: got %b/%b want 1/%b", c, c_out_valid, c_out_data, prev); end
            end
            prev = c_in_data;
            @(posedge clk);
            @(negedge clk);
        end
        c_in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_fill_stall();
        test_bubble();
        test_flush();
        test_async_reset();
        test_random();
        test_depth1();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/dff_pipe.md
Name: dff_pipe

Overview:
- Parametrised successor to the single-bit D flip-flop: a chain of DEPTH registers, each WIDTH bits wide.
- Each stage has a valid bit, and a valid/ready handshake runs on both ends.
- Bubbles collapse: an empty stage accepts new data even when downstream is stalled.
- Used as a generic delay line and elastic buffer between datapath blocks, with synchronous flush and occupancy reporting.

Parameters:
- WIDTH, 8, data width in bits (>=1).
- DEPTH, 3, number of register stages (>=1). DEPTH=0 is illegal.
- RESET_VAL, 0, WIDTH-bit value loaded into every data register on reset.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset. reset=0 clears the block immediately, independent of clk.
- flush  input  1  synchronous clear of all valid bits.
- in_valid  input  1  upstream has data.
- in_ready  output  1  block accepts in_data this cycle.
- in_data  input  WIDTH  input data.
- out_valid  output  1  last stage holds valid data.
- out_ready  input  1  downstream accepts out_data.
- out_data  output  WIDTH  last-stage data register.
- occupancy  output  $clog2(DEPTH+1)  number of valid stages, 0..DEPTH.

Behaviour:
- Stages are numbered 0 (input side) to DEPTH-1 (output side). Each stage k holds v[k] and d[k].
- Downstream ready: nr[DEPTH-1]=out_ready; nr[k]=rdy[k+1] for k<DEPTH-1.
- Stage ready: rdy[k] = !v[k] | nr[k].
- in_ready = rdy[0] & !flush. This is combinational from out_ready (ready pass-through); no register is placed in the ready path.
- Input transfer: in_valid & in_ready. Output transfer: out_valid & out_ready.
- Stage k loads when rdy[k] is high:
  - v[k] <= (k==0 ? in_valid & in_ready : v[k-1]);
  - d[k] <= (k==0 ? in_data : d[k-1]), updated only when the incoming valid is 1;
  - otherwise d holds its value.
- While rdy[k] is low, stage k holds both v[k] and d[k].
- out_valid = v[DEPTH-1] & !flush. out_data = d[DEPTH-1] at all times; its value is don't-care when out_valid=0.
- Latency: with no stall, an item accepted at edge t appears with out_valid=1 in the cycle after edge t+DEPTH-1. Example: DEPTH=1 gives out_valid in the next cycle.
- Throughput: 1 item/cycle while out_ready=1.
- Full (all v=1) with out_ready=0: in_ready=0 and all stages hold. Full with out_ready=1: in_ready=1 in the same cycle, and the chain shifts by one.
- Partially full with out_ready=0: items advance into empty stages until they pack against the output.
- flush=1:
  - next edge sets all v to 0; d registers are untouched;
  - in_ready=0 and out_valid=0 during the flush cycle, so no transfer happens on either side;
  - flush takes priority over all loads.
- occupancy = popcount(v), derived combinationally from the valid registers. Range 0..DEPTH; never wraps.
- Reset (reset=0, asynchronous, also mid-transfer):
  - all v=0 and all d=RESET_VAL immediately;
  - out_valid=0, out_data=RESET_VAL, occupancy=0;
  - in_ready=1 once flush=0;
  - any in-flight item is discarded.
- Reset deassertion is synchronised externally; the block needs no internal synchroniser.
- X on in_data while in_valid=0 must never propagate into a valid stage.

Decomposition:
- Shared package dff_pipe_pkg holds:
  - OCC_W(DEPTH) width function;
  - default WIDTH/DEPTH/RESET_VAL constants, reused by the testbench.
- One sub-module, dff_pipe_stage: a single valid+data register with async active-low reset, in_valid/in_data, nr input and rdy output.
- dff_pipe instantiates DEPTH stages in a generate loop and computes occupancy.

Test Plan (WIDTH=8, DEPTH=3, RESET_VAL=8'h00 unless stated):
- Reset then stream: hold reset=0 for 2 cycles, then reset=1 with out_ready=1; send 8'hA1, 8'hA2, 8'hA3 on consecutive cycles.
  - Required: out_valid first rises 3 cycles after the 8'hA1 accept edge; outputs are A1, A2, A3 back-to-back; occupancy peaks at 3.
- Fill and stall: out_ready=0, in_valid=1 with 8'h10..8'h14.
  - Required: exactly 3 accepts (10, 11, 12), then in_ready=0 and occupancy=3.
  - Then out_ready=1 for one cycle: 8'h10 is delivered, 8'h13 is accepted in the same cycle, occupancy stays 3.
- Bubble collapse: with out_ready=0, send 8'h55, idle 2 cycles, send 8'h66.
  - Required: both items pack at the output end; occupancy=2; then 55 and 66 emerge on consecutive cycles once out_ready=1.
- Flush: with 3 items stored, pulse flush=1 for one cycle while in_valid=1.
  - Required: in_ready=0 and out_valid=0 during the pulse; occupancy=0 after the edge; no item is accepted or delivered.
- Async reset mid-operation: assert reset=0 between clock edges while occupancy=2.
  - Required: out_valid=0, out_data=8'h00, occupancy=0 before the next edge.
  - Repeat with RESET_VAL=8'hFF: out_data=8'hFF.
- DEPTH=1, WIDTH=1: toggle in_data every cycle with in_valid=1, out_ready=1.
  - Required: out_data equals in_data delayed by one cycle, and in_ready stays 1 throughout.
